// File: rtl/int_seq_if.sv
// Decoder/address-unit side signals of the interrupt sequencer.
// master: the sequencer itself; slave: the surrounding CPU datapath.
interface int_seq_if;
    logic       RDY;
    logic       NMI_n;
    logic       IRQ_n;
    logic       I_flag;
    logic       sync;
    logic       brk;
    logic [4:0] dec_op;
    logic [4:0] op;
    logic       WE;
    logic       B_out;
    logic       set_I;
    logic       busy;
    logic       ack;

    modport master (
        input  RDY, NMI_n, IRQ_n, I_flag, sync, brk, dec_op,
        output op, WE, B_out, set_I, busy, ack
    );

    modport slave (
        output RDY, NMI_n, IRQ_n, I_flag, sync, brk, dec_op,
        input  op, WE, B_out, set_I, busy, ack
    );
endinterface

// File: rtl/int_seq.sv
// Interrupt/reset sequencer: arbitrates RESET/NMI/IRQ/BRK and steps the address-bus-low
// op through push PCH, push PCL, push P and the vector fetch; passes dec_op through when idle.
module int_seq (
    input  logic      clk,
    input  logic      RES_n,
    int_seq_if.master bus
);
    // Address op encodings shared with the address units (states.i).
    localparam logic [4:0] AB_FETCH = 5'b00000;
    localparam logic [4:0] AB_DATA  = 5'b00001;
    localparam logic [4:0] AB_VECN  = 5'b01001;
    localparam logic [4:0] AB_VECR  = 5'b01010;
    localparam logic [4:0] AB_VECI  = 5'b01011;
    localparam logic [4:0] AB_IRQ0  = 5'b10000;
    localparam logic [4:0] AB_BRK   = 5'b10001;
    localparam logic [4:0] AB_BRK1  = 5'b10010;
    localparam logic [4:0] AB_PHA   = 5'b10011;

    typedef enum logic [2:0] {
        StIdle, StInt0, StPushH, StPushL, StPushP, StVecL, StVecH
    } state_t;

    typedef enum logic [1:0] {SrcRst, SrcNmi, SrcIrq, SrcBrk} src_t;

    state_t state_q, state_d;
    src_t   src_q, src_d;
    logic   nmi_prev_q, nmi_pend_q;
    logic   nmi_edge, irq_req, hijack;

    always_comb begin
        nmi_edge = nmi_prev_q & ~bus.NMI_n;
        irq_req  = ~bus.IRQ_n & ~bus.I_flag;
        // A pending NMI steals the vector of an IRQ/BRK sequence already under way.
        hijack   = nmi_pend_q & ((src_q == SrcIrq) | (src_q == SrcBrk));
        state_d  = state_q;
        src_d    = src_q;
        if (bus.RDY) begin
            case (state_q)
                StIdle: begin
                    if (bus.sync) begin
                        if (nmi_pend_q) begin
                            state_d = StInt0;
                            src_d   = SrcNmi;
                        end else if (irq_req) begin
                            state_d = StInt0;
                            src_d   = SrcIrq;
                        end else if (bus.brk) begin
                            state_d = StInt0;
                            src_d   = SrcBrk;
                        end
                    end
                end
                StInt0:  state_d = StPushH;
                StPushH: state_d = StPushL;
                StPushL: state_d = StPushP;
                StPushP: state_d = StVecL;
                StVecL:  state_d = StVecH;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        bus.op = bus.dec_op;
        case (state_q)
            StInt0:  bus.op = (src_q == SrcBrk) ? AB_FETCH : AB_IRQ0;
            StPushH: bus.op = AB_BRK;
            StPushL: bus.op = AB_BRK1;
            StPushP: bus.op = AB_PHA;
            StVecL: begin
                if (src_q == SrcRst) begin
                    bus.op = AB_VECR;
                end else if (src_q == SrcNmi || hijack) begin
                    bus.op = AB_VECN;
                end else begin
                    bus.op = AB_VECI;
                end
            end
            StVecH:  bus.op = AB_DATA;
            default: bus.op = bus.dec_op;
        endcase
    end

    always_ff @(posedge clk) begin
        // Edge detector runs even during reset and stalls so no NMI edge is lost.
        nmi_prev_q <= bus.NMI_n;
        if (!RES_n) begin
            state_q    <= StInt0;
            src_q      <= SrcRst;
            nmi_pend_q <= 1'b0;
            bus.busy   <= 1'b1;
            bus.WE     <= 1'b0;
            bus.set_I  <= 1'b0;
            bus.ack    <= 1'b0;
            bus.B_out  <= 1'b0;
        end else begin
            if (bus.RDY && state_q == StVecL && (src_q == SrcNmi || hijack)) begin
                nmi_pend_q <= 1'b0;
            end
            if (nmi_edge) begin
                nmi_pend_q <= 1'b1;
            end
            if (bus.RDY) begin
                state_q   <= state_d;
                src_q     <= src_d;
                bus.busy  <= state_d != StIdle;
                bus.WE    <= (state_d inside {StPushH, StPushL, StPushP}) && src_d != SrcRst;
                bus.set_I <= state_d == StVecL;
                bus.ack   <= state_d == StVecH;
                bus.B_out <= src_d == SrcBrk && state_d != StIdle;
            end
        end
    end
endmodule

// File: tb/tb_int_seq.sv
// Directed bench for int_seq: reset, IRQ masking, BRK, NMI hijack, stall and mid-sequence reset,
// all with hand-computed op/strobe expectations.
module tb_int_seq;
    localparam logic [4:0] AB_FETCH = 5'b00000;
    localparam logic [4:0] AB_DATA  = 5'b00001;
    localparam logic [4:0] AB_VECN  = 5'b01001;
    localparam logic [4:0] AB_VECR  = 5'b01010;
    localparam logic [4:0] AB_VECI  = 5'b01011;
    localparam logic [4:0] AB_IRQ0  = 5'b10000;
    localparam logic [4:0] AB_BRK   = 5'b10001;
    localparam logic [4:0] AB_BRK1  = 5'b10010;
    localparam logic [4:0] AB_PHA   = 5'b10011;
    localparam logic [4:0] DEC_OP   = 5'b00111;

    logic clk = 1'b0;
    logic RES_n;
    int   n_checks = 0;
    int   n_fail = 0;

    int_seq_if bus ();

    int_seq dut (
        .clk   (clk),
        .RES_n (RES_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, ".busy"}, {7'd0, bus.busy}, 8'd0);
        check_eq({tag, ".op"}, {3'd0, bus.op}, {3'd0, DEC_OP});
    endtask

    // Called at the falling edge of the INT0 cycle; walks the whole sequence and ends in IDLE.
    task automatic run_seq(input string tag, input logic [4:0] op0, input logic [4:0] vec,
                           input logic we, input logic b);
        logic [4:0] ops [6];
        ops[0] = op0; ops[1] = AB_BRK; ops[2] = AB_BRK1;
        ops[3] = AB_PHA; ops[4] = vec; ops[5] = AB_DATA;
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("%s.c%0d.op", tag, i), {3'd0, bus.op}, {3'd0, ops[i]});
            check_eq($sformatf("%s.c%0d.we", tag, i), {7'd0, bus.WE},
                     {7'd0, we && i >= 1 && i <= 3});
            check_eq($sformatf("%s.c%0d.b", tag, i), {7'd0, bus.B_out}, {7'd0, b});
            check_eq($sformatf("%s.c%0d.seti", tag, i), {7'd0, bus.set_I}, {7'd0, i == 4});
            check_eq($sformatf("%s.c%0d.ack", tag, i), {7'd0, bus.ack}, {7'd0, i == 5});
            check_eq($sformatf("%s.c%0d.busy", tag, i), {7'd0, bus.busy}, 8'd1);
            @(negedge clk);
        end
        check_idle({tag, ".end"});
    endtask

    initial begin
        RES_n      = 1'b0;
        bus.RDY    = 1'b1;
        bus.NMI_n  = 1'b1;
        bus.IRQ_n  = 1'b1;
        bus.I_flag = 1'b1;
        bus.sync   = 1'b0;
        bus.brk    = 1'b0;
        bus.dec_op = DEC_OP;

        // Reset held for 3 clocks, then the RESET sequence reading the FC vector.
        @(negedge clk);
        check_eq("rst.busy", {7'd0, bus.busy}, 8'd1);
        check_eq("rst.we", {7'd0, bus.WE}, 8'd0);
        check_eq("rst.seti", {7'd0, bus.set_I}, 8'd0);
        check_eq("rst.ack", {7'd0, bus.ack}, 8'd0);
        check_eq("rst.b", {7'd0, bus.B_out}, 8'd0);
        check_eq("rst.op", {3'd0, bus.op}, {3'd0, AB_IRQ0});
        @(negedge clk);
        @(negedge clk);
        RES_n = 1'b1;
        run_seq("rst", AB_IRQ0, AB_VECR, 1'b0, 1'b0);

        // IRQ masked by I, then taken once I clears.
        bus.IRQ_n = 1'b0;
        bus.sync  = 1'b1;
        @(negedge clk);
        check_idle("irqmask");
        bus.I_flag = 1'b0;
        @(negedge clk);
        bus.sync  = 1'b0;
        bus.IRQ_n = 1'b1;
        run_seq("irq", AB_IRQ0, AB_VECI, 1'b1, 1'b0);

        // BRK.
        bus.sync = 1'b1;
        bus.brk  = 1'b1;
        @(negedge clk);
        bus.sync = 1'b0;
        bus.brk  = 1'b0;
        run_seq("brk", AB_FETCH, AB_VECI, 1'b1, 1'b1);

        // IRQ and BRK at the same boundary: IRQ wins.
        bus.sync  = 1'b1;
        bus.brk   = 1'b1;
        bus.IRQ_n = 1'b0;
        @(negedge clk);
        bus.sync  = 1'b0;
        bus.brk   = 1'b0;
        bus.IRQ_n = 1'b1;
        run_seq("irqbrk", AB_IRQ0, AB_VECI, 1'b1, 1'b0);

        // NMI edge during PUSH_L of a BRK takes over the vector.
        bus.sync = 1'b1;
        bus.brk  = 1'b1;
        @(negedge clk);
        bus.sync = 1'b0;
        bus.brk  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("hij.pushl", {3'd0, bus.op}, {3'd0, AB_BRK1});
        bus.NMI_n = 1'b0;
        @(negedge clk);
        check_eq("hij.pushp", {3'd0, bus.op}, {3'd0, AB_PHA});
        @(negedge clk);
        check_eq("hij.vec", {3'd0, bus.op}, {3'd0, AB_VECN});
        check_eq("hij.b", {7'd0, bus.B_out}, 8'd1);
        check_eq("hij.seti", {7'd0, bus.set_I}, 8'd1);
        @(negedge clk);
        check_eq("hij.vech", {3'd0, bus.op}, {3'd0, AB_DATA});
        @(negedge clk);
        bus.sync = 1'b1;
        @(negedge clk);
        check_idle("hij.nosecond");
        bus.sync  = 1'b0;
        bus.NMI_n = 1'b1;

        // Four-cycle stall in PUSH_H with an NMI edge inside it.
        bus.sync = 1'b1;
        bus.brk  = 1'b1;
        @(negedge clk);
        bus.sync = 1'b0;
        bus.brk  = 1'b0;
        @(negedge clk);
        bus.RDY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq($sformatf("stall%0d.op", i), {3'd0, bus.op}, {3'd0, AB_BRK});
            check_eq($sformatf("stall%0d.we", i), {7'd0, bus.WE}, 8'd1);
            if (i == 1) bus.NMI_n = 1'b0;
        end
        bus.RDY = 1'b1;
        @(negedge clk);
        check_eq("stall.pushl", {3'd0, bus.op}, {3'd0, AB_BRK1});
        @(negedge clk);
        @(negedge clk);
        check_eq("stall.vec", {3'd0, bus.op}, {3'd0, AB_VECN});
        @(negedge clk);
        @(negedge clk);
        bus.sync = 1'b1;
        @(negedge clk);
        check_idle("stall.end");
        bus.sync  = 1'b0;
        bus.NMI_n = 1'b1;

        // Plain NMI waits for sync.
        @(negedge clk);
        bus.NMI_n = 1'b0;
        @(negedge clk);
        check_idle("nmi.wait");
        bus.NMI_n = 1'b1;
        bus.sync  = 1'b1;
        @(negedge clk);
        bus.sync = 1'b0;
        run_seq("nmi", AB_IRQ0, AB_VECN, 1'b1, 1'b0);

        // Reset in PUSH_P of an IRQ, with an NMI pending that reset must discard.
        bus.sync  = 1'b1;
        bus.IRQ_n = 1'b0;
        @(negedge clk);
        bus.sync  = 1'b0;
        bus.IRQ_n = 1'b1;
        bus.NMI_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check_eq("mid.pushp.we", {7'd0, bus.WE}, 8'd1);
        check_eq("mid.pushp.op", {3'd0, bus.op}, {3'd0, AB_PHA});
        RES_n = 1'b0;
        @(negedge clk);
        RES_n = 1'b1;
        check_eq("mid.we", {7'd0, bus.WE}, 8'd0);
        check_eq("mid.op", {3'd0, bus.op}, {3'd0, AB_IRQ0});
        run_seq("mid", AB_IRQ0, AB_VECR, 1'b0, 1'b0);
        bus.sync = 1'b1;
        @(negedge clk);
        check_idle("mid.nopend");
        bus.sync  = 1'b0;
        bus.NMI_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
